pc_fetch_ctrl: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch.
- Selects each next fetch address from three sources: sequential PC+4, a branch/jump redirect from the next-PC mux, or a trap redirect.
- Issues one outstanding request at a time to the instruction bus.
- Discards fetches made stale by a redirect, and buffers one fetched instruction toward the IDU under stall.

---
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer with
// redirect/trap steering, stale-response drop and a one-entry IDU buffer.
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            trap_vld,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            stall,
  output logic            ifu_req_vld,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_req_rdy,
  input  logic            ifu_rsp_vld,
  input  logic [XLEN-1:0] ifu_rsp_inst,
  output logic            inst_vld,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            flush,
  output logic            misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, tgt;
  logic            active, redir, hs, buf_free, load;

  always_comb begin
    active   = (state != S_IDLE);
    redir    = active && (trap_vld || redir_vld);
    tgt      = (trap_vld ? trap_pc : redir_pc) & ~XLEN'(3);
    hs       = (state == S_REQ) && ifu_req_rdy;
    buf_free = !inst_vld || !stall;
    // a response coinciding with a redirect belongs to the old path
    load     = (state == S_WAIT) && ifu_rsp_vld && buf_free && !redir;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (redir)   state_nxt = hs ? S_DROP : S_REQ;
        else if (hs) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redir)     state_nxt = ifu_rsp_vld ? S_REQ : S_DROP;
        else if (load) state_nxt = S_REQ;
      end
      S_DROP: begin
        if (!redir && ifu_rsp_vld) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (redir)     pc_nxt = tgt;
    else if (load) pc_nxt = pc + XLEN'(4);
  end

  assign ifu_req_vld  = (state == S_REQ);
  assign ifu_req_addr = pc;
  // trap vectors are never reported as misaligned
  assign misalign     = active && !trap_vld && redir_vld && (redir_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      flush    <= 1'b0;
      inst_vld <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      flush <= redir;
      if (redir) begin
        inst_vld <= 1'b0;
      end else if (load) begin
        inst_vld <= 1'b1;
        inst     <= ifu_rsp_inst;
        inst_pc  <= pc;
      end else if (!stall) begin
        inst_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed cycle-by-cycle vectors for pc_fetch_ctrl plus short hand sequences.
module tb_pc_fetch_ctrl;
  localparam int XLEN = 32;
  localparam int NV   = 37;

  logic            clk, rst_n;
  logic            redir_vld, trap_vld, stall, ifu_req_rdy, ifu_rsp_vld;
  logic [XLEN-1:0] redir_pc, trap_pc, ifu_rsp_inst;
  logic            ifu_req_vld, inst_vld, flush, misalign;
  logic [XLEN-1:0] ifu_req_addr, inst, inst_pc;

  pc_fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redir_vld(redir_vld), .redir_pc(redir_pc),
    .trap_vld(trap_vld), .trap_pc(trap_pc),
    .stall(stall),
    .ifu_req_vld(ifu_req_vld), .ifu_req_addr(ifu_req_addr), .ifu_req_rdy(ifu_req_rdy),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_inst(ifu_rsp_inst),
    .inst_vld(inst_vld), .inst(inst), .inst_pc(inst_pc),
    .flush(flush), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, trap, redir, stall, rdy, rsp;
    logic [31:0] tpc, rpc, rinst;
    logic        e_rv, e_iv, e_fl, e_mis;
    logic [31:0] e_addr, e_inst, e_ipc;
  } vec_t;

  vec_t vec [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
      logic r, logic t, logic [31:0] tpc, logic d, logic [31:0] rpc,
      logic st, logic rdy, logic rsp, logic [31:0] ri,
      logic rv, logic [31:0] addr, logic iv, logic [31:0] ins, logic [31:0] ipc,
      logic fl, logic mis);
    vec_t v;
    v.rst_n = r; v.trap = t; v.tpc = tpc; v.redir = d; v.rpc = rpc;
    v.stall = st; v.rdy = rdy; v.rsp = rsp; v.rinst = ri;
    v.e_rv = rv; v.e_addr = addr; v.e_iv = iv; v.e_inst = ins; v.e_ipc = ipc;
    v.e_fl = fl; v.e_mis = mis;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; trap_vld = v.trap; trap_pc = v.tpc; redir_vld = v.redir;
    redir_pc = v.rpc; stall = v.stall; ifu_req_rdy = v.rdy; ifu_rsp_vld = v.rsp;
    ifu_rsp_inst = v.rinst;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           rst trp tpc           rdr rpc           stl rdy rsp rinst          rv addr          iv inst          ipc           fl mis
    vec[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hDEAD,      0, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[1]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hDEAD,      0, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hA0,        0, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h4,        1, 32'hA0,     32'h0,        0, 0);
    vec[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hA4,        0, 32'h4,        0, 32'hA0,     32'h0,        0, 0);
    vec[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8,        1, 32'hA4,     32'h4,        0, 0);
    vec[7]  = mk(1, 0, 32'h0,        1, 32'h100,      0, 0, 0, 32'h0,         0, 32'h8,        0, 32'hA4,     32'h4,        0, 0);
    vec[8]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hA8,        0, 32'h100,      0, 32'hA4,     32'h4,        1, 0);
    vec[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h100,      0, 32'hA4,     32'h4,        0, 0);
    vec[10] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hB00,       0, 32'h100,      0, 32'hA4,     32'h4,        0, 0);
    vec[11] = mk(1, 1, 32'h200,      1, 32'h101,      0, 0, 0, 32'h0,         1, 32'h104,      1, 32'hB00,    32'h100,      0, 0);
    vec[12] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h200,      0, 32'hB00,    32'h100,      1, 0);
    vec[13] = mk(1, 0, 32'h0,        1, 32'h102,      0, 1, 0, 32'h0,         1, 32'h200,      0, 32'hB00,    32'h100,      0, 1);
    vec[14] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h100,      0, 32'hB00,    32'h100,      1, 0);
    vec[15] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hBAD0,      0, 32'h100,      0, 32'hB00,    32'h100,      0, 0);
    vec[16] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h100,      0, 32'hB00,    32'h100,      0, 0);
    vec[17] = mk(1, 0, 32'h0,        1, 32'h10,       0, 0, 1, 32'hBAD,       0, 32'h100,      0, 32'hB00,    32'h100,      0, 0);
    vec[18] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h10,       0, 32'hB00,    32'h100,      1, 0);
    vec[19] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'hC10,       0, 32'h10,       0, 32'hB00,    32'h100,      0, 0);
    vec[20] = mk(1, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0,         1, 32'h14,       1, 32'hC10,    32'h10,       0, 0);
    vec[21] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'hC14,       0, 32'h14,       1, 32'hC10,    32'h10,       0, 0);
    vec[22] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'hC14,       0, 32'h14,       1, 32'hC10,    32'h10,       0, 0);
    vec[23] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hC14,       0, 32'h14,       1, 32'hC10,    32'h10,       0, 0);
    vec[24] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h18,       1, 32'hC14,    32'h14,       0, 0);
    vec[25] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h18,       0, 32'hC14,    32'h14,       0, 0);
    vec[26] = mk(1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,         1, 32'h18,       0, 32'hC14,    32'h14,       0, 0);
    vec[27] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'hC14,    32'h14,       1, 0);
    vec[28] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hEEE,       0, 32'hFFFFFFFC, 0, 32'hC14,    32'h14,       0, 0);
    vec[29] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h0,        1, 32'hEEE,    32'hFFFFFFFC, 0, 0);
    vec[30] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hF00,       0, 32'h0,        0, 32'hEEE,    32'hFFFFFFFC, 0, 0);
    vec[31] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h4,        1, 32'hF00,    32'h0,        0, 0);
    vec[32] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h4,        0, 32'hF00,    32'h0,        0, 0);
    vec[33] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h5A,        0, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[34] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[35] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h77,        0, 32'h0,        0, 32'h0,      32'h0,        0, 0);
    vec[36] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h4,        1, 32'h77,     32'h0,        0, 0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      n_cmp++;
      if (ifu_req_vld !== vec[i].e_rv || ifu_req_addr !== vec[i].e_addr ||
          inst_vld !== vec[i].e_iv || inst !== vec[i].e_inst || inst_pc !== vec[i].e_ipc ||
          flush !== vec[i].e_fl || misalign !== vec[i].e_mis) begin
        n_bad++;
        $display("FAIL vec%0d: got rv=%b addr=%h iv=%b inst=%h ipc=%h fl=%b mis=%b expected rv=%b addr=%h iv=%b inst=%h ipc=%h fl=%b mis=%b",
                 i, ifu_req_vld, ifu_req_addr, inst_vld, inst, inst_pc, flush, misalign,
                 vec[i].e_rv, vec[i].e_addr, vec[i].e_iv, vec[i].e_inst, vec[i].e_ipc,
                 vec[i].e_fl, vec[i].e_mis);
      end
    end

    // DUT now in REQ at pc 0x4: an unaligned trap vector is aligned but not flagged
    @(negedge clk);
    drive(mk(1, 1, 32'h203, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("trap_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("trap_flush", {31'h0, flush}, 32'h1);
    chk("trap_addr", ifu_req_addr, 32'h200);
    @(negedge clk);
    #1 chk("flush_one_cycle", {31'h0, flush}, 32'h0);

    // reset again and wait (bounded) for the first request
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ifu_req_rdy = 1'b1;
    begin
      int cyc = 0;
      while (ifu_req_vld !== 1'b1 && cyc < 4) begin
        @(negedge clk);
        cyc++;
      end
      #1 chk("first_req_seen", {31'h0, ifu_req_vld}, 32'h1);
      chk("first_req_latency", cyc, 1);
      chk("first_req_addr", ifu_req_addr, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
